// File: rtl/if_prefetch_queue_pkg.sv
// Shared types for the fetch-stage prefetch queue: FSM encoding, queue entry layout, PC step helper.
package if_prefetch_queue_pkg;

  localparam int          INSTR_W = 32;
  localparam int          PC_W    = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc_incr;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bundle: ID redirect, instruction-memory req/ack/rvalid channel, and queue head toward IF/ID.
interface if_prefetch_queue_if;
  import if_prefetch_queue_pkg::*;

  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc_incr;
  logic               out_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_ack, imem_rvalid, imem_rdata,
    output out_valid, out_instr, out_pc_incr,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_ack, imem_rvalid, imem_rdata,
    input  out_valid, out_instr, out_pc_incr,
    output out_ready
  );

endinterface

// File: rtl/if_prefetch_queue_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; head is visible combinationally from rd_ptr.
// Push lands next cycle; push+pop together keep count; caller must not push when full or pop when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_queue.sv
// IF front end: owns fetch PC, issues one imem request at a time, queues {pc+4, instr} for IF/ID.
// ack@n -> rvalid>=n+1 -> out_valid n+2; requests stall when queue+in-flight would exceed DEPTH.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  if_prefetch_queue_if.master   bus
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  fetch_pc_nxt;

  logic             req;
  logic             push;
  logic             pop;
  logic             flush;
  logic             empty;
  logic             full;
  logic             head_vld;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign flush = bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  // In WAIT, fetch_pc has already advanced past the outstanding request, so it is that request's PC+4.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    req          = (state == ST_FETCH) && !full && !rst;

    unique case (state)
      ST_FETCH: begin
        if (req && bus.imem_ack) begin
          fetch_pc_nxt = pc_next(fetch_pc);
          state_nxt    = bus.redirect_valid ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          push      = !bus.redirect_valid;
          state_nxt = ST_FETCH;
        end else if (bus.redirect_valid) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.imem_rvalid) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase

    if (bus.redirect_valid) fetch_pc_nxt = bus.redirect_pc;
  end

  assign push_entry.pc_incr = fetch_pc;
  assign push_entry.instr   = bus.imem_rdata;

  // A redirect hides the head for the cycle so IF/ID cannot consume an entry being flushed.
  assign head_vld = !empty && !bus.redirect_valid && !rst;
  assign pop      = head_vld && bus.out_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head),
    .count    (count)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.out_valid   = head_vld;
  assign bus.out_instr   = empty ? '0 : head.instr;
  assign bus.out_pc_incr = empty ? '0 : head.pc_incr;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench: a behavioural memory with variable latency plus a transaction-level queue model.
module tb_if_prefetch_queue;
  import if_prefetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;

  if_prefetch_queue_if bus ();

  if_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_incr;
    logic [31:0] instr;
  } ent_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          inflight;
  bit          in_stale;
  int          in_wait;
  logic [31:0] in_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(3))
      0:       return 32'h0000_0100;
      1:       return 32'hFFFF_FFF8;
      default: return r & 32'h0000_FFFC;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    inflight = 1'b0;
    in_stale = 1'b0;
    in_wait  = 0;
    m_pc     = RESET_PC;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst                = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.imem_ack       = 1'($urandom_range(1));
      bus.imem_rvalid    = 1'b0;
      bus.out_ready      = 1'b1;
      @(negedge clk);
      chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    end
    model_reset();
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input int p_ack, input int p_ready, input int p_redir,
                       input int lat_max, input int p_spur, input int p_rst,
                       input int redir_only_busy);
    logic        exp_req;
    logic        exp_ov;
    logic        rv;
    logic        redir;
    logic [31:0] old_pc;
    @(posedge clk); #1;
    rst = (p_rst > 0) && inflight && ($urandom_range(99) < p_rst);
    bus.out_ready      = ($urandom_range(99) < p_ready);
    bus.redirect_valid = !rst && (redir_only_busy == 0 || inflight) && ($urandom_range(99) < p_redir);
    bus.redirect_pc    = pick_target();
    rv = 1'b0;
    if (inflight) begin
      if (in_wait == 0) rv = 1'b1;
      else in_wait--;
    end else begin
      rv = ($urandom_range(99) < p_spur);
    end
    bus.imem_rvalid = rv;
    bus.imem_rdata  = (inflight && rv) ? mem_word(in_addr) : $urandom;
    bus.imem_ack    = ($urandom_range(99) < p_ack);
    redir           = bus.redirect_valid;

    @(negedge clk);
    exp_req = !rst && !inflight && (mq.size() < DEPTH);
    exp_ov  = !rst && (mq.size() > 0) && !redir;
    chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (!rst) begin
      if (mq.size() > 0) begin
        chk("out_instr", bus.out_instr, mq[0].instr);
        chk("out_pc_incr", bus.out_pc_incr, mq[0].pc_incr);
      end else begin
        chk("out_instr_empty", bus.out_instr, 32'h0);
        chk("out_pc_incr_empty", bus.out_pc_incr, 32'h0);
      end
    end

    if (rst) begin
      model_reset();
    end else begin
      old_pc = m_pc;
      if (inflight && rv) begin
        if (!in_stale && !redir) mq.push_back('{pc_incr: in_addr + 32'd4, instr: mem_word(in_addr)});
        inflight = 1'b0;
      end
      if (exp_ov && bus.out_ready) void'(mq.pop_front());
      if (exp_req && bus.imem_ack) begin
        inflight = 1'b1;
        in_stale = 1'b0;
        in_addr  = old_pc;
        in_wait  = $urandom_range(lat_max - 1, 0);
        m_pc     = old_pc + 32'd4;
      end
      if (redir) begin
        mq.delete();
        m_pc = bus.redirect_pc;
        if (inflight) in_stale = 1'b1;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_ack       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.out_ready      = 1'b0;
    model_reset();

    do_reset(2);
    // zero-wait streaming
    repeat (20) cycle(100, 100, 0, 1, 0, 0, 0);
    // fill to DEPTH with no pops, then drain
    repeat (30) cycle(100, 0, 0, 1, 0, 0, 0);
    repeat (6)  cycle(100, 100, 0, 1, 0, 0, 0);
    repeat (20) cycle(100, 0, 0, 1, 0, 0, 0);
    repeat (40) cycle(100, 40, 0, 1, 0, 0, 0);
    // redirects while a request is outstanding
    repeat (80) cycle(100, 50, 20, 2, 0, 0, 1);
    // redirects at any time, including alongside ack and pop
    repeat (80) cycle(100, 70, 20, 1, 0, 0, 0);
    // general random traffic with variable latency and stray rvalid
    repeat (3000) cycle(60, 50, 6, 3, 5, 0, 0);
    // 3-cycle memory with resets landing mid-request
    repeat (300) cycle(80, 60, 3, 3, 0, 10, 0);
    repeat (20) cycle(100, 100, 0, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
